// File: rtl/dma_desc_fifo.sv
// DMA descriptor FIFO: buffers descriptors written through the CSR block,
// tags each accepted descriptor with a running sequence number, and hands
// them to the DMA engine in order via a first-word fall-through
// valid/ready port. Overflow and zero-length pushes are dropped and flagged
// with sticky error bits.
module dma_desc_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 32,
  parameter int CTRL_W = 32,
  parameter int SEQ_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     desc_go,
  input  logic [ADDR_W-1:0]        desc_src_addr,
  input  logic [ADDR_W-1:0]        desc_dest_addr,
  input  logic [LEN_W-1:0]         desc_length,
  input  logic [CTRL_W-1:0]        desc_control,
  input  logic                     flush,
  input  logic                     stop,
  input  logic                     err_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_src_addr,
  output logic [ADDR_W-1:0]        out_dest_addr,
  output logic [LEN_W-1:0]         out_length,
  output logic [CTRL_W-1:0]        out_control,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     buffer_full,
  output logic                     buffer_empty,
  output logic                     err_overflow,
  output logic                     err_zero_len
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [CTRL_W-1:0] ctrl;
    logic [SEQ_W-1:0]  seq;
  } desc_t;

  desc_t              mem [DEPTH];
  desc_t              head;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [SEQ_W-1:0]   seq_cnt;

  logic               len_nz;
  logic               pop;
  logic               push_req;
  logic               push;
  logic               ovf_evt;
  logic               zl_evt;

  assign buffer_empty = (count == '0);
  assign buffer_full  = (count == CNT_W'(DEPTH));
  assign fill_level   = count;

  // First-word fall-through: the head slot is always visible on out_*.
  assign head          = mem[rd_ptr];
  assign out_valid     = !buffer_empty && !stop;
  assign out_src_addr  = head.src;
  assign out_dest_addr = head.dst;
  assign out_length    = head.len;
  assign out_control   = head.ctrl;
  assign out_seq       = head.seq;

  // Transfer qualifiers and error events for this cycle.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    len_nz   = 1'b0;
    pop      = 1'b0;
    push_req = 1'b0;
    push     = 1'b0;
    ovf_evt  = 1'b0;
    zl_evt   = 1'b0;

    len_nz   = (desc_length != '0);
    pop      = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_req = desc_go && len_nz && (!buffer_full || pop);
    // Flush discards the incoming descriptor, but it has still consumed
    // its sequence tag (push_req drives the tag counter, not push).
    push     = push_req && !flush;
    ovf_evt  = desc_go && len_nz && buffer_full && !pop && !flush;
    zl_evt   = desc_go && !len_nz;
  end

  // Descriptor storage write port.
  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers and count, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{src:  desc_src_addr,
                       dst:  desc_dest_addr,
                       len:  desc_length,
                       ctrl: desc_control,
                       seq:  seq_cnt};
    end
  end

  // Pointers, occupancy, sequence counter and sticky error flags.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      seq_cnt      <= '0;
      err_overflow <= 1'b0;
      err_zero_len <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end

      // Wraps naturally from all-ones to zero.
      if (push_req) seq_cnt <= seq_cnt + SEQ_W'(1);

      // A same-cycle error event wins over err_clear.
      err_overflow <= ovf_evt || (err_overflow && !err_clear);
      err_zero_len <= zl_evt  || (err_zero_len && !err_clear);
    end
  end

endmodule

// File: doc/dma_desc_fifo.md
DMA_DESC_FIFO -- requirements
Module: dma_desc_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, descriptor slots (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default 64, source/destination address width.
REQ-003 SHALL have parameter LEN_W, default 32, transfer length width in bytes.
REQ-004 SHALL have parameter CTRL_W, default 32, descriptor control word width.
REQ-005 SHALL have parameter SEQ_W, default 16, sequence tag width.
REQ-006 clk  in  1  single clock; all logic on posedge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 desc_go  in  1  one-cycle push strobe from CSR descriptor_control.go.
REQ-009 desc_src_addr  in  ADDR_W  descriptor source address.
REQ-010 desc_dest_addr  in  ADDR_W  descriptor destination address.
REQ-011 desc_length  in  LEN_W  descriptor byte length.
REQ-012 desc_control  in  CTRL_W  descriptor control word.
REQ-013 flush  in  1  discard all queued descriptors.
REQ-014 stop  in  1  pause dispatch while high.
REQ-015 err_clear  in  1  clear sticky error flags.
REQ-016 out_valid  out  1  head descriptor available to engine.
REQ-017 out_ready  in  1  engine accepts head descriptor.
REQ-018 out_src_addr, out_dest_addr  out  ADDR_W each  head addresses.
REQ-019 out_length  out  LEN_W  head length.
REQ-020 out_control  out  CTRL_W  head control word.
REQ-021 out_seq  out  SEQ_W  tag assigned to head at push.
REQ-022 fill_level  out  $clog2(DEPTH)+1  occupied slots.
REQ-023 buffer_full, buffer_empty  out  1 each  fill_level==DEPTH / ==0.
REQ-024 err_overflow, err_zero_len  out  1 each  sticky error flags.

Function
REQ-025 Push SHALL occur when desc_go && desc_length!=0 && !flush && (fill_level<DEPTH || pop).
REQ-026 Pop SHALL occur when out_valid && out_ready && !stop.
REQ-027 out_valid SHALL equal !buffer_empty && !stop; out_* SHALL show the oldest entry (first-word fall-through).
REQ-028 Latency desc_go to out_valid on empty FIFO SHALL be exactly 1 cycle.
REQ-029 out_* SHALL remain stable while out_valid && !out_ready.
REQ-030 Simultaneous push and pop SHALL leave fill_level unchanged, including when full.
REQ-031 desc_go while full without pop SHALL drop the descriptor and set err_overflow next cycle.
REQ-032 desc_go with desc_length==0 SHALL drop the descriptor and set err_zero_len next cycle; seq counter unchanged.
REQ-033 Each push SHALL tag the entry with seq counter value, then increment it, wrapping 2^SEQ_W-1 to 0.
REQ-034 Read/write pointers SHALL wrap modulo DEPTH.
REQ-035 flush SHALL empty the FIFO next cycle, overriding same-cycle push and pop; seq counter and error flags unaffected.
REQ-036 err_clear SHALL clear both flags next cycle; a same-cycle error event SHALL win (flag stays set).
REQ-037 stop SHALL not block pushes.

Reset
REQ-038 reset SHALL force fill_level=0, buffer_empty=1, buffer_full=0, out_valid=0, seq counter=0, error flags=0, pointers=0; priority over all inputs.
REQ-039 Reset mid-operation SHALL discard queued entries; storage contents need not be cleared.

Verification
REQ-040 Empty, push src=0x1000 dst=0x2000 len=0x40 -> next cycle out_valid=1, out_seq=0, fill_level=1.
REQ-041 DEPTH=16: 17 pushes, out_ready=0 -> buffer_full=1 at 16, 17th dropped, err_overflow=1; drain yields seq 0..15 in order.
REQ-042 Full FIFO, push and pop same cycle -> fill_level stays 16, no overflow, new entry seq=16 last out.
REQ-043 Push len=0 -> fill_level unchanged, err_zero_len=1; err_clear -> 0 next cycle.
REQ-044 Queue 3, stop=1 with out_ready=1 -> out_valid=0, nothing popped; stop=0 -> 3 pops in order.
REQ-045 Queue 5 then flush with same-cycle push -> fill_level=0, buffer_empty=1; next push gets seq=6.
